// File: rtl/max_pool2_pkg.sv
// Shared constants, state encoding and DRAM address packing for the
// layer-2 max-pooling stage.
package max_pool2_pkg;

    localparam int ADDR_W = 18;

    localparam logic [ADDR_W-1:0] IN_BASE  = 18'd131072;
    localparam logic [ADDR_W-1:0] OUT_BASE = 18'd65536;

    localparam int IN_DIM  = 10;
    localparam int OUT_DIM = 5;
    localparam int CH_DIM  = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        DONE
    } state_t;

    // Both planes share one layout: z strides 1024 words, y strides 32 words.
    function automatic logic [ADDR_W-1:0] pack_addr(
        input logic [ADDR_W-1:0] base,
        input logic [3:0]        z,
        input logic [3:0]        y,
        input logic [3:0]        x
    );
        return base + {4'd0, z, 10'd0} + {9'd0, y, 5'd0} + {14'd0, x};
    endfunction

endpackage

// File: rtl/max_pool2_cnt.sv
// Window and output-pixel counter chain (win fastest inside a pixel, then
// ox, oy, oz) with flags for the last window and the last pixel of a frame.
module pool_cnt
    import max_pool2_pkg::*;
(
    input  logic       clk,
    input  logic       srstn,
    input  logic       win_step,
    input  logic       pix_step,
    output logic [1:0] win,
    output logic [2:0] ox,
    output logic [2:0] oy,
    output logic [3:0] oz,
    output logic       last_win,
    output logic       last_pix
);

    logic ox_last;
    logic oy_last;
    logic oz_last;

    assign ox_last  = (ox == 3'(OUT_DIM - 1));
    assign oy_last  = (oy == 3'(OUT_DIM - 1));
    assign oz_last  = (oz == 4'(CH_DIM - 1));
    assign last_pix = ox_last && oy_last && oz_last;
    assign last_win = (win == 2'd3);

    always_ff @(posedge clk) begin
        if (!srstn) begin
            win <= '0;
            ox  <= '0;
            oy  <= '0;
            oz  <= '0;
        end else begin
            if (win_step) begin
                win <= win + 2'd1;
            end
            if (pix_step) begin
                if (last_pix) begin
                    ox <= '0;
                    oy <= '0;
                    oz <= '0;
                end else if (ox_last) begin
                    ox <= '0;
                    if (oy_last) begin
                        oy <= '0;
                        oz <= oz + 4'd1;
                    end else begin
                        oy <= oy + 3'd1;
                    end
                end else begin
                    ox <= ox + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/max_pool2.sv
// 2x2 stride-2 signed max pooling of the 10x10x16 conv2 map into the 5x5x16
// fully-connected input map, one window read per cycle from DRAM.
module max_pool2
    import max_pool2_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18
) (
    input  logic                         clk,
    input  logic                         srstn,
    input  logic                         enable,
    input  logic                         dram_valid,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic        [ADDR_WIDTH-1:0] addr_in,
    output logic        [ADDR_WIDTH-1:0] addr_out,
    output logic                         dram_en_rd,
    output logic                         dram_en_wr,
    output logic                         done
);

    state_t state;
    state_t state_nxt;

    logic [1:0] win;
    logic [2:0] ox;
    logic [2:0] oy;
    logic [3:0] oz;
    logic       last_win;
    logic       last_pix;

    logic                         ld_en;
    logic                         ld_first;
    logic signed [DATA_WIDTH-1:0] max_val;

    logic unused_dram_valid;
    assign unused_dram_valid = dram_valid;

    pool_cnt u_cnt (
        .clk      (clk),
        .srstn    (srstn),
        .win_step (state == RD),
        .pix_step (state == WR),
        .win      (win),
        .ox       (ox),
        .oy       (oy),
        .oz       (oz),
        .last_win (last_win),
        .last_pix (last_pix)
    );

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RD;
            RD:      if (last_win) state_nxt = WAIT;
            WAIT:    state_nxt = WR;
            WR:      state_nxt = last_pix ? DONE : RD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Window (2oy + win[1], 2ox + win[0]) concatenates directly into y/x.
    always_comb begin
        addr_in    = '0;
        dram_en_rd = 1'b0;
        dram_en_wr = 1'b0;
        done       = 1'b0;
        case (state)
            RD: begin
                addr_in    = ADDR_WIDTH'(pack_addr(IN_BASE, oz, {oy, win[1]}, {ox, win[0]}));
                dram_en_rd = 1'b1;
            end
            WAIT:    dram_en_rd = 1'b1;
            WR:      dram_en_wr = 1'b1;
            DONE:    done       = 1'b1;
            default: ;
        endcase
    end

    assign addr_out = ADDR_WIDTH'(pack_addr(OUT_BASE, oz, {1'b0, oy}, {1'b0, ox}));
    assign data_out = max_val;

    // Read data returns one cycle after its RD, so the load flags lag by one.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            ld_en    <= 1'b0;
            ld_first <= 1'b0;
        end else begin
            ld_en    <= (state == RD);
            ld_first <= (state == RD) && (win == 2'd0);
        end
    end

    // Strict greater-than keeps the current value on ties.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            max_val <= '0;
        end else if (ld_en && (ld_first || (data_in > max_val))) begin
            max_val <= data_in;
        end
    end

endmodule

// File: tb/tb_max_pool2.sv
// Self-checking bench for max_pool2: DRAM read model, frame-level reference
// model of the pooled output, and directed scenarios with random data.
module tb_max_pool2;

    localparam int IN_BASE  = 131072;
    localparam int OUT_BASE = 65536;
    localparam int MEM_SZ   = 16384;

    logic               clk;
    logic               srstn;
    logic               enable;
    logic               dram_valid;
    logic signed [31:0] data_in;
    logic signed [31:0] data_out;
    logic        [17:0] addr_in;
    logic        [17:0] addr_out;
    logic               dram_en_rd;
    logic               dram_en_wr;
    logic               done;

    max_pool2 #(.DATA_WIDTH(32), .ADDR_WIDTH(18)) dut (
        .clk        (clk),
        .srstn      (srstn),
        .enable     (enable),
        .dram_valid (dram_valid),
        .data_in    (data_in),
        .data_out   (data_out),
        .addr_in    (addr_in),
        .addr_out   (addr_out),
        .dram_en_rd (dram_en_rd),
        .dram_en_wr (dram_en_wr),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic signed [31:0] mem [0:MEM_SZ-1];

    int                 total;
    int                 bad;
    int                 cyc;
    int                 done_cnt;
    int                 done_cyc;
    logic        [17:0] wa_q [$];
    logic signed [31:0] wd_q [$];
    int                 wc_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe the current cycle, advance one clock, then return the read
    // data for the address that was presented in the observed cycle.
    task automatic step();
        logic        rd;
        logic [17:0] a;
        int          idx;
        rd = dram_en_rd;
        a  = addr_in;
        if (dram_en_wr) begin
            wa_q.push_back(addr_out);
            wd_q.push_back(data_out);
            wc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        idx = int'(a) - IN_BASE;
        if (rd && idx >= 0 && idx < MEM_SZ) data_in = mem[idx];
        else data_in = 32'sh7FFF_FFFF;
    endtask

    function automatic logic signed [31:0] mem_at(input int z, input int y, input int x);
        return mem[z * 1024 + y * 32 + x];
    endfunction

    function automatic logic signed [31:0] ref_max(input int z, input int oy, input int ox);
        logic signed [31:0] m;
        m = mem_at(z, 2 * oy, 2 * ox);
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
                if (mem_at(z, 2 * oy + dy, 2 * ox + dx) > m) m = mem_at(z, 2 * oy + dy, 2 * ox + dx);
        return m;
    endfunction

    task automatic fill(input int kind);
        logic signed [31:0] v;
        for (int i = 0; i < MEM_SZ; i++) mem[i] = 32'sd0;
        for (int z = 0; z < 16; z++)
            for (int y = 0; y < 10; y++)
                for (int x = 0; x < 10; x++) begin
                    case (kind)
                        0: v = z * 1000 + y * 10 + x;
                        1: v = $signed($urandom());
                        2: v = (y % 2 == 0 && x % 2 == 0) ? 32'sh0005_0000 : -32'sh0001_0000;
                        3: case ((y % 2) * 2 + (x % 2))
                               0:       v = -32'sd196608;
                               1:       v = -32'sd131072;
                               2:       v = -32'sd458752;
                               default: v = -32'sd262144;
                           endcase
                        default: v = 32'sh0001_0000;
                    endcase
                    mem[z * 1024 + y * 32 + x] = v;
                end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"},  data_out,   0);
        check({tag, "_ain"},   addr_in,    0);
        check({tag, "_aout"},  addr_out,   OUT_BASE);
        check({tag, "_enrd"},  dram_en_rd, 0);
        check({tag, "_enwr"},  dram_en_wr, 0);
        check({tag, "_done"},  done,       0);
    endtask

    task automatic run_frame(input bit hold, input int last);
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        cyc      = 0;
        enable   = 1'b1;
        while (cyc < last) begin
            step();
            if (!hold) enable = 1'b0;
            if (cyc == 1) begin
                check("rd1_en", dram_en_rd, 1);
                check("rd1_addr", addr_in, IN_BASE);
            end
            if (cyc == 5) begin
                check("wait_en", dram_en_rd, 1);
                check("wait_addr", addr_in, 0);
            end
            if (hold && cyc == 2402) check("idle_enrd", dram_en_rd, 0);
            if (hold && cyc == 2403) begin
                check("restart_enrd", dram_en_rd, 1);
                check("restart_addr", addr_in, IN_BASE);
            end
        end
    endtask

    task automatic verify(input string tag);
        int n;
        int nx;
        check({tag, "_nwr"}, wa_q.size(), 400);
        check({tag, "_donecyc"}, done_cyc, 2401);
        check({tag, "_donecnt"}, done_cnt, 1);
        n  = 0;
        nx = 0;
        for (int oz = 0; oz < 16; oz++)
            for (int oy = 0; oy < 5; oy++)
                for (int ox = 0; ox < 5; ox++) begin
                    if (n < wa_q.size()) begin
                        check($sformatf("%s_a%0d", tag, n), wa_q[n], OUT_BASE + oz * 1024 + oy * 32 + ox);
                        check($sformatf("%s_d%0d", tag, n), wd_q[n], ref_max(oz, oy, ox));
                        check($sformatf("%s_c%0d", tag, n), wc_q[n], 6 + 6 * n);
                        if ($isunknown(wd_q[n])) nx++;
                    end
                    n++;
                end
        check({tag, "_nox"}, nx, 0);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        cyc        = 0;
        done_cnt   = 0;
        done_cyc   = -1;
        srstn      = 1'b0;
        enable     = 1'b0;
        dram_valid = 1'b0;
        data_in    = 32'sd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        srstn = 1'b1;
        step();
        check_reset_outputs("idle");

        fill(0);
        run_frame(1'b0, 2405);
        verify("ramp");
        if (wd_q.size() == 400) begin
            check("ramp_first_d", wd_q[0], 11);
            check("ramp_last_a", wa_q[399], 81028);
            check("ramp_last_d", wd_q[399], 15099);
        end

        fill(1);
        run_frame(1'b0, 2405);
        verify("rand");

        fill(2);
        run_frame(1'b0, 2405);
        verify("topleft");
        if (wd_q.size() > 0) check("topleft_d0", wd_q[0], 32'h0005_0000);

        fill(3);
        run_frame(1'b0, 2405);
        verify("neg");
        if (wd_q.size() > 0) check("neg_d0", wd_q[0], -32'sd131072);

        fill(4);
        run_frame(1'b1, 2403);
        verify("equal_hold");
        if (wd_q.size() > 0) check("equal_d0", wd_q[0], 32'h0001_0000);
        enable = 1'b0;
        srstn  = 1'b0;
        step();
        srstn = 1'b1;
        step();

        fill(1);
        run_frame(1'b0, 1000);
        srstn = 1'b0;
        step();
        check_reset_outputs("midrst");
        srstn = 1'b1;
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_cnt = 0;
        repeat (60) step();
        check("midrst_nwr", wa_q.size(), 0);
        check("midrst_ndone", done_cnt, 0);

        fill(0);
        run_frame(1'b0, 2405);
        verify("rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/max_pool2.md
# max_pool2

Layer-2 max-pooling stage of the LeNet datapath, directly upstream of the fully-connected stage. Reads the 10x10x16 conv2 feature map from DRAM, takes the signed maximum of each non-overlapping 2x2 window (stride 2), and writes the 5x5x16 result to the DRAM region the fully-connected stage loads as its input feature map. Shares the same single-port-style DRAM interface (`enable`/`done`, separate read and write address buses) as the other layer blocks.

## Interface
- DATA_WIDTH, 32, pixel word width, signed two's complement, Q16.16
- ADDR_WIDTH, 18, DRAM word address width
- clk  in  1  clock
- srstn  in  1  reset, synchronous, active-low
- enable  in  1  start request, sampled only in IDLE
- dram_valid  in  1  unused; kept for port compatibility with other layer blocks
- data_in  in  DATA_WIDTH  DRAM read data, valid one cycle after the matching addr_in
- data_out  out  DATA_WIDTH  pooled pixel to write
- addr_in  out  ADDR_WIDTH  DRAM read address
- addr_out  out  ADDR_WIDTH  DRAM write address
- dram_en_rd  out  1  read enable
- dram_en_wr  out  1  write strobe, one cycle per pooled pixel
- done  out  1  one-cycle completion pulse

## Operation
- Address map, both planes: base + (z<<10) + (y<<5) + x. Input base IN_BASE=131072 (x,y 0..9); output base OUT_BASE=65536 (x,y 0..4), which is the layout the fully-connected stage reads.
- Counters: ox 0..4 (fastest), oy 0..4, oz 0..15; window index win 0..3.
- Window order: win0=(2oy,2ox), win1=(2oy,2ox+1), win2=(2oy+1,2ox), win3=(2oy+1,2ox+1).
- FSM: IDLE -> RD when enable; RD holds 4 cycles (win 0..3), then WAIT (1), then WR (1); WR -> RD with the next pixel, or -> DONE after pixel (ox,oy,oz)=(4,4,15); DONE -> IDLE unconditionally.
- Max register: on a data cycle for win0, load data_in; on data cycles for win1..3, replace the value if data_in > max (signed 32-bit compare); ties keep the current value. A data cycle is the cycle after the RD cycle that issued the address; it is tracked by registered flags ld_en and ld_first.
- addr_in = IN_BASE + window address in RD, else 0.
- dram_en_rd = 1 in RD and WAIT, else 0.
- dram_en_wr = 1 only in WR; data_out = max register; addr_out = OUT_BASE + (oz<<10)+(oy<<5)+ox, driven continuously from the counters.
- Counters advance in WR and clear to 0 on the WR->DONE transition.
- enable is ignored outside IDLE.
- No rounding and no ReLU: the operation is a pure max.

## Timing
- Reset: state IDLE, all counters 0, max register 0, ld flags 0; outputs data_out=0, addr_in=0, addr_out=65536, dram_en_rd=0, dram_en_wr=0, done=0.
- enable high in IDLE at cycle 0 gives: RD cycles 1-4, WAIT 5, first WR 6.
- Each pixel takes 6 cycles. The last WR is at cycle 2400 and done pulses at cycle 2401; the block is back in IDLE at 2402 and can restart there.
- enable held high continuously restarts the block immediately after DONE.
- srstn low mid-frame: the block returns to IDLE on the next edge, pending ld flags are cleared, and no write is issued in the following cycle.

## Structure
- A shared package holds IN_BASE, OUT_BASE, the input and output dimensions (10, 5, 16), the state encoding (IDLE, RD, WAIT, WR, DONE), and the address-pack function.
- One natural sub-module, `pool_cnt`: the win/ox/oy/oz counter chain with a last-pixel flag. The FSM, max register and address muxes stay in the top module.

## Test plan
- Ramp input, value = z*1000+y*10+x at each input address -> output(ox,oy,oz) = oz*1000+(2oy+1)*10+2ox+1; 400 writes total; done at cycle 2401.
- Max at the top-left of every window (win0=5.0, others -1.0) -> every output = 0x00050000.
- All inputs negative (-3,-2,-7,-4 in Q16.16) -> output = -2, showing the compare is signed.
- Equal values in a window (all 0x00010000) -> output 0x00010000; no X values on data_out.
- Write-address sequence -> 65536, 65537 … 65540, 65568 …; pixel (4,4,15) writes to 65536+15360+132 = 81028.
- srstn pulsed at cycle 1000 with enable low -> no further writes and all outputs at reset values; a re-enable reruns from pixel (0,0,0).
